// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall unit:
// FSM state encoding, register-specifier width, reg-zero constant and
// the packed control bundle driven back into the pipeline.
package hazard_stall_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_MEMWAIT = 2'd2
  } state_t;

  // Pipeline control bundle, MSB first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN    = 5'b11000;
  localparam ctrl_t CTRL_STALL  = 5'b00100;
  localparam ctrl_t CTRL_FREEZE = 5'b00001;
  localparam ctrl_t CTRL_RESET  = 5'b00100;

  // A producer only creates a hazard when it writes a real register
  // that the consumer actually reads; $0 is hard-wired and never does.
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] dst,
                                     input logic [REG_ADDR_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_stall_counter.sv
// Saturating performance counter: counts enabled cycles and sticks at
// all-ones instead of wrapping back to zero.
module hazard_stall_unit_stall_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state in clocked blocks uses <= so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall unit. Detects load-use, branch-operand and
// data-memory-wait hazards that forwarding cannot cover, freezes PC and
// IF/ID, bubbles ID/EX, flushes IF/ID on a taken branch, and counts
// cycles with PC_Write low. All controls are combinational on the
// current inputs; only state, rem and the counter are registered.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRs,
  input  logic [REG_ADDR_W-1:0] IF_ID_RegRt,
  input  logic                  ID_Branch,
  input  logic                  ID_BranchTaken,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegRt,
  input  logic [REG_ADDR_W-1:0] ID_EX_RegDst,
  input  logic                  ID_EX_MemRead,
  input  logic                  ID_EX_RegWrite,
  input  logic [REG_ADDR_W-1:0] EX_MEM_RegRd,
  input  logic                  EX_MEM_MemRead,
  input  logic                  Mem_Busy,
  output logic                  PC_Write,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Bubble,
  output logic                  IF_ID_Flush,
  output logic                  Pipe_Freeze,
  output logic [CNT_W-1:0]      Stall_Cycles
);

  logic       lu, br1, brl2, brl1;
  logic [1:0] need;
  state_t     state, state_next, eval_state;
  logic [1:0] rem, rem_next;
  ctrl_t      ctrl_raw, ctrl;

  // Hazard terms against the instruction sitting in ID.
  assign lu   = ID_EX_MemRead & (reg_match(ID_EX_RegRt, IF_ID_RegRs) |
                                 reg_match(ID_EX_RegRt, IF_ID_RegRt));
  assign br1  = ID_Branch & ID_EX_RegWrite & ~ID_EX_MemRead &
                (reg_match(ID_EX_RegDst, IF_ID_RegRs) |
                 reg_match(ID_EX_RegDst, IF_ID_RegRt));
  assign brl2 = ID_Branch & lu;
  assign brl1 = ID_Branch & EX_MEM_MemRead &
                (reg_match(EX_MEM_RegRd, IF_ID_RegRs) |
                 reg_match(EX_MEM_RegRd, IF_ID_RegRt));

  // Number of bubble cycles the instruction in ID needs.
  always_comb begin
    // NOTE: every comb-assigned signal gets a default first so no path
    // leaves it unassigned and infers a latch.
    need = 2'd0;
    if (brl2)                   need = 2'd2;
    else if (lu | br1 | brl1)   need = 2'd1;
  end

  // Effective behaviour this cycle: leaving MEMWAIT acts immediately as
  // the interrupted STALL (rem left) or as a fresh RUN evaluation.
  always_comb begin
    eval_state = state;
    if (state == ST_MEMWAIT) eval_state = (rem != 2'd0) ? ST_STALL : ST_RUN;
  end

  // State and remaining-stall registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      rem   <= 2'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  // Next-state logic; a memory wait parks the FSM and preserves rem.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    if (Mem_Busy) begin
      state_next = ST_MEMWAIT;
    end else begin
      case (eval_state)
        ST_STALL: begin
          rem_next   = (rem != 2'd0) ? rem - 2'd1 : 2'd0;
          state_next = (rem <= 2'd1) ? ST_RUN : ST_STALL;
        end
        default: begin
          state_next = ST_RUN;
          if (need != 2'd0) begin
            rem_next = need - 2'd1;
            if (need == 2'd2) state_next = ST_STALL;
          end
        end
      endcase
    end
  end

  // Control outputs: memory wait beats stall, stall beats flush.
  always_comb begin
    ctrl_raw = CTRL_RUN;
    if (Mem_Busy) begin
      ctrl_raw = CTRL_FREEZE;
    end else if ((eval_state == ST_STALL) || (need != 2'd0)) begin
      ctrl_raw = CTRL_STALL;
    end else begin
      ctrl_raw.if_id_flush = ID_Branch & ID_BranchTaken;
    end
  end

  // Reset forces the safe control pattern without waiting for a clock.
  assign ctrl = rst_n ? ctrl_raw : CTRL_RESET;

  assign PC_Write     = ctrl.pc_write;
  assign IF_ID_Write  = ctrl.if_id_write;
  assign ID_EX_Bubble = ctrl.id_ex_bubble;
  assign IF_ID_Flush  = ctrl.if_id_flush;
  assign Pipe_Freeze  = ctrl.pipe_freeze;

  // The counter is held in reset while rst_n is low, so it can take the
  // ungated enable.
  logic stall_en;
  assign stall_en = ~ctrl_raw.pc_write;

  hazard_stall_unit_stall_counter #(.W(CNT_W)) stall_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .count (Stall_Cycles)
  );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit. Expected control vectors
// and counts are queued when stimulus is driven and compared when the
// DUT is sampled on the falling edge. A second instance with a 3-bit
// counter exercises saturation.
module tb_hazard_stall_unit;
  import hazard_stall_unit_pkg::*;

  localparam int CNT_W = 32;
  localparam int SAT_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [REG_ADDR_W-1:0] rs, rt, ex_rt, ex_dst, mem_rd;
  logic br, taken, ex_memread, ex_regwrite, mem_memread, busy;

  logic pc_write, if_id_write, bubble, flush, freeze;
  logic [CNT_W-1:0] stall_cycles;
  logic s_pc_write, s_if_id_write, s_bubble, s_flush, s_freeze;
  logic [SAT_W-1:0] s_stall_cycles;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegRs(rs), .IF_ID_RegRt(rt),
    .ID_Branch(br), .ID_BranchTaken(taken),
    .ID_EX_RegRt(ex_rt), .ID_EX_RegDst(ex_dst),
    .ID_EX_MemRead(ex_memread), .ID_EX_RegWrite(ex_regwrite),
    .EX_MEM_RegRd(mem_rd), .EX_MEM_MemRead(mem_memread),
    .Mem_Busy(busy),
    .PC_Write(pc_write), .IF_ID_Write(if_id_write),
    .ID_EX_Bubble(bubble), .IF_ID_Flush(flush),
    .Pipe_Freeze(freeze), .Stall_Cycles(stall_cycles)
  );

  hazard_stall_unit #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegRs(rs), .IF_ID_RegRt(rt),
    .ID_Branch(br), .ID_BranchTaken(taken),
    .ID_EX_RegRt(ex_rt), .ID_EX_RegDst(ex_dst),
    .ID_EX_MemRead(ex_memread), .ID_EX_RegWrite(ex_regwrite),
    .EX_MEM_RegRd(mem_rd), .EX_MEM_MemRead(mem_memread),
    .Mem_Busy(busy),
    .PC_Write(s_pc_write), .IF_ID_Write(s_if_id_write),
    .ID_EX_Bubble(s_bubble), .IF_ID_Flush(s_flush),
    .Pipe_Freeze(s_freeze), .Stall_Cycles(s_stall_cycles)
  );

  // {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Pipe_Freeze}
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_FLUSH  = 5'b11010;
  localparam logic [4:0] O_STALL  = 5'b00100;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b00100;

  typedef struct {
    string       tag;
    logic [4:0]  ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs = '0; rt = '0; ex_rt = '0; ex_dst = '0; mem_rd = '0;
    br = 1'b0; taken = 1'b0; ex_memread = 1'b0; ex_regwrite = 1'b0;
    mem_memread = 1'b0; busy = 1'b0;
  endtask

  // Load in EX writing $2, branch in ID comparing $2 with $5 (taken).
  task automatic setup_load_branch();
    clear_inputs();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rt = 5'd2; ex_dst = 5'd2;
    br = 1'b1; taken = 1'b1; rs = 5'd2; rt = 5'd5;
  endtask

  // Inputs are already applied; queue the expectation, sample at the
  // falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [4:0] ctrl_exp);
    exp_t e;
    if (!rst_n) exp_cnt = 32'd0;
    e.tag = tag; e.ctrl = ctrl_exp; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.tag, ".ctrl"}, {27'd0, pc_write, if_id_write, bubble, flush, freeze}, {27'd0, e.ctrl});
    check({e.tag, ".cnt"}, stall_cycles, e.cnt);
    check({e.tag, ".sat_ctrl"}, {27'd0, s_pc_write, s_if_id_write, s_bubble, s_flush, s_freeze},
          {27'd0, e.ctrl});
    check({e.tag, ".sat_cnt"}, {29'd0, s_stall_cycles}, (e.cnt > 32'd7) ? 32'd7 : e.cnt);
    if (rst_n && !e.ctrl[4]) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    #1 rst_n = 1'b0;

    step("reset", O_RESET);
    rst_n = 1'b1;
    step("idle", O_RUN);

    // lw $2 in EX, add $3,$2,$4 in ID
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rt = 5'd2; ex_dst = 5'd2; rs = 5'd2; rt = 5'd4;
    step("lu_rs", O_STALL);
    clear_inputs(); rs = 5'd2; rt = 5'd4;
    step("lu_after", O_RUN);

    // load-use through rt
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rt = 5'd9; ex_dst = 5'd9; rs = 5'd1; rt = 5'd9;
    step("lu_rt", O_STALL);
    clear_inputs();
    step("lu_rt_after", O_RUN);

    // ALU result in EX feeding a non-branch is forwarded, no stall
    ex_regwrite = 1'b1; ex_dst = 5'd3; rs = 5'd3; rt = 5'd3;
    step("alu_fwd", O_RUN);

    // lw $0 in EX, ID reads $0
    clear_inputs(); ex_memread = 1'b1; ex_rt = 5'd0; ex_dst = 5'd0;
    step("lw_r0", O_RUN);

    // lw $2 in EX, beq $2,$5 taken: two stalls, then flush
    setup_load_branch();
    step("brl2_a", O_STALL);
    clear_inputs(); br = 1'b1; taken = 1'b1; rs = 5'd2; rt = 5'd5;
    step("brl2_b", O_STALL);
    step("brl2_flush", O_FLUSH);
    clear_inputs();
    step("brl2_done", O_RUN);

    // add $7 in EX, bne $7,$0 taken
    ex_regwrite = 1'b1; ex_dst = 5'd7; br = 1'b1; taken = 1'b1; rs = 5'd7; rt = 5'd0;
    step("br1", O_STALL);
    clear_inputs(); br = 1'b1; taken = 1'b1; rs = 5'd7; rt = 5'd0;
    step("br1_flush", O_FLUSH);
    clear_inputs();
    step("br1_done", O_RUN);

    // load in MEM feeding a not-taken branch: one stall
    mem_memread = 1'b1; mem_rd = 5'd6; br = 1'b1; rs = 5'd1; rt = 5'd6;
    step("brl1", O_STALL);
    clear_inputs(); br = 1'b1; rs = 5'd1; rt = 5'd6;
    step("brl1_go", O_RUN);

    // persistent load-use drives both counters well past 7
    clear_inputs(); ex_memread = 1'b1; ex_rt = 5'd8; rs = 5'd8;
    for (int i = 0; i < 10; i++) step("lu_run", O_STALL);
    clear_inputs();
    step("lu_run_done", O_RUN);

    // memory wait in RUN, then hazard evaluated in the release cycle
    busy = 1'b1; ex_memread = 1'b1; ex_rt = 5'd2; rs = 5'd2;
    step("busy_run", O_FREEZE);
    busy = 1'b0;
    step("busy_reeval", O_STALL);
    clear_inputs();
    step("busy_done", O_RUN);

    // memory wait in the middle of a two-cycle branch stall
    rst_n = 1'b0;
    step("reset2", O_RESET);
    rst_n = 1'b1;
    setup_load_branch();
    step("mw_a", O_STALL);
    clear_inputs(); busy = 1'b1;
    for (int i = 0; i < 3; i++) step("mw_busy", O_FREEZE);
    busy = 1'b0;
    step("mw_resume", O_STALL);
    br = 1'b1; taken = 1'b1; rs = 5'd2; rt = 5'd5;
    step("mw_flush", O_FLUSH);
    check("mw_stall_cycles", stall_cycles, 32'd5);

    // asynchronous reset while in STALL
    setup_load_branch();
    step("rs_a", O_STALL);
    clear_inputs(); br = 1'b1; taken = 1'b1; rs = 5'd2; rt = 5'd5;
    rst_n = 1'b0;
    #1;
    check("rs_async.ctrl", {27'd0, pc_write, if_id_write, bubble, flush, freeze}, {27'd0, O_RESET});
    check("rs_async.cnt", stall_cycles, 32'd0);
    step("rs_hold", O_RESET);
    rst_n = 1'b1;
    step("rs_after", O_FLUSH);
    clear_inputs();
    step("rs_done", O_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
